// File: rtl/avalon_timer_pkg.sv
// Shared definitions for the Avalon-MM timer: register map, field positions and bus FSM states.
package avalon_timer_pkg;

  localparam logic [1:0] AddrCount   = 2'd0;
  localparam logic [1:0] AddrCompare = 2'd1;
  localparam logic [1:0] AddrCtrl    = 2'd2;
  localparam logic [1:0] AddrStatus  = 2'd3;

  localparam int unsigned CtrlEnBit         = 0;
  localparam int unsigned CtrlAutoReloadBit = 1;
  localparam int unsigned CtrlIrqEnBit      = 2;
  localparam int unsigned CtrlPrescaleLsb   = 16;

  localparam int unsigned StatusMatchBit = 0;
  localparam int unsigned StatusOvfBit   = 1;

  typedef enum logic [1:0] {
    StIdle,
    StAccept,
    StResp
  } bus_state_e;

  // Replace only the byte lanes selected by be.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/avalon_timer_prescaler.sv
// Prescale divider: counts 0..limit while enabled and emits a one-cycle tick at limit.
module timer_prescaler
  import avalon_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] limit,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt_q;

  assign tick = enable && (cnt_q == limit);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/avalon_timer.sv
// Avalon-MM slave timer: COUNT/COMPARE/CTRL/STATUS registers, prescaled counting and level irq.
module avalon_timer
  import avalon_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic [3:0]  avs_byteenable,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_waitrequest,
  output logic        inr_irq
);

  localparam logic [31:0] CtrlMask =
      32'h7 | (((32'h1 << PRESCALE_WIDTH) - 32'h1) << CtrlPrescaleLsb);

  bus_state_e  state_q;
  logic [31:0] count_q, compare_q, ctrl_q, count_d;
  logic        match_q, ovf_q, irq_q;
  logic [31:0] readdata_q, rd_mux, status_word;
  logic        readdatavalid_q;

  logic wr_acc, wr_count, wr_compare, wr_ctrl, wr_status;
  logic tick, compare_hit, match_set, ovf_set, clr_match, clr_ovf;
  logic ctrl_en, ctrl_auto, ctrl_irq_en;
  logic [PRESCALE_WIDTH-1:0] prescale;

  // Read has priority when both strobes are presented.
  assign wr_acc     = (state_q == StAccept) && avs_write && !avs_read;
  assign wr_count   = wr_acc && (avs_address == AddrCount);
  assign wr_compare = wr_acc && (avs_address == AddrCompare);
  assign wr_ctrl    = wr_acc && (avs_address == AddrCtrl);
  assign wr_status  = wr_acc && (avs_address == AddrStatus);

  assign ctrl_en     = ctrl_q[CtrlEnBit];
  assign ctrl_auto   = ctrl_q[CtrlAutoReloadBit];
  assign ctrl_irq_en = ctrl_q[CtrlIrqEnBit];
  assign prescale    = ctrl_q[CtrlPrescaleLsb +: PRESCALE_WIDTH];

  timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (ctrl_en),
    .clear  (wr_ctrl),
    .limit  (prescale),
    .tick   (tick)
  );

  // A COUNT write on a tick edge discards that tick's effects.
  assign compare_hit = (count_q == compare_q);
  assign match_set   = tick && compare_hit && !wr_count;
  assign ovf_set     = tick && (&count_q) && !(compare_hit && ctrl_auto) && !wr_count;
  assign clr_match   = wr_status && avs_byteenable[0] && avs_writedata[StatusMatchBit];
  assign clr_ovf     = wr_status && avs_byteenable[0] && avs_writedata[StatusOvfBit];

  always_comb begin
    count_d = count_q;
    if (wr_count) begin
      count_d = byte_merge(count_q, avs_writedata, avs_byteenable);
    end else if (tick) begin
      count_d = (compare_hit && ctrl_auto) ? 32'd0 : count_q + 32'd1;
    end
  end

  always_comb begin
    status_word                 = '0;
    status_word[StatusMatchBit] = match_q;
    status_word[StatusOvfBit]   = ovf_q;
    case (avs_address)
      AddrCount:   rd_mux = count_q;
      AddrCompare: rd_mux = compare_q;
      AddrCtrl:    rd_mux = ctrl_q;
      default:     rd_mux = status_word;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      compare_q <= '1;
      ctrl_q    <= '0;
      match_q   <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      if (wr_compare) compare_q <= byte_merge(compare_q, avs_writedata, avs_byteenable);
      if (wr_ctrl) ctrl_q <= byte_merge(ctrl_q, avs_writedata, avs_byteenable) & CtrlMask;
      // Set beats clear when both land on the same edge.
      match_q <= (match_q && !clr_match) || match_set;
      ovf_q   <= (ovf_q && !clr_ovf) || ovf_set;
      irq_q   <= ctrl_irq_en && (match_q || ovf_q);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      readdatavalid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (avs_read || avs_write) state_q <= StAccept;
        end
        StAccept: begin
          state_q <= StResp;
          if (avs_read) begin
            readdata_q      <= rd_mux;
            readdatavalid_q <= 1'b1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign avs_waitrequest   = (avs_read || avs_write) && (state_q != StAccept);
  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = readdatavalid_q;
  assign inr_irq           = irq_q;

endmodule

// File: doc/avalon_timer.md
AVALON_TIMER -- requirements
Module: avalon_timer

Interface
REQ-001 The module SHALL have parameter PRESCALE_WIDTH, default 16, giving the width of the CTRL prescale field and the internal prescale counter (range 1..16).
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port avs_address, input, 2 bits: word register select (0 COUNT, 1 COMPARE, 2 CTRL, 3 STATUS).
REQ-005 The module SHALL have port avs_byteenable, input, 4 bits: per-byte write enable.
REQ-006 The module SHALL have ports avs_read and avs_write, inputs, 1 bit each: access requests; both high together is illegal, and read wins.
REQ-007 The module SHALL have port avs_writedata, input, 32 bits: write data.
REQ-008 The module SHALL have port avs_readdata, output, 32 bits: read data, valid only while avs_readdatavalid is high.
REQ-009 The module SHALL have port avs_readdatavalid, output, 1 bit: read response strobe.
REQ-010 The module SHALL have port avs_waitrequest, output, 1 bit: stall for a presented access.
REQ-011 The module SHALL have port inr_irq, output, 1 bit: level interrupt to the clarvi_avalon core.

Function
REQ-012 The bus FSM SHALL have states IDLE, ACCEPT and RESP.
- IDLE: a read or write raises avs_waitrequest combinationally, then goes to ACCEPT.
- ACCEPT: avs_waitrequest is low. A write takes effect at this edge. A read captures data at this edge. Then goes to RESP.
- RESP: avs_readdatavalid is high for one cycle after a read, low after a write. avs_waitrequest is high if an access is presented. Then goes to IDLE.
REQ-013 Each access SHALL therefore complete in exactly 2 cycles, with read data 1 cycle after acceptance and at most one access per 3 cycles.
REQ-014 Writes SHALL update only the bytes whose avs_byteenable bit is set; reads SHALL have no side effects.
REQ-015 CTRL fields:
- bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN.
- bits[16 +: PRESCALE_WIDTH] PRESCALE.
- Other bits read 0.
REQ-016 STATUS bits: bit0 MATCH, bit1 OVF. Each is write-1-to-clear. Other bits read 0.
REQ-017 While EN=1, the prescale counter SHALL count 0..PRESCALE and produce a one-cycle tick when equal to PRESCALE, then return to 0; PRESCALE=0 ticks every cycle.
REQ-018 Any accepted write to CTRL SHALL clear the prescale counter; EN=0 SHALL hold the counter and COUNT.
REQ-019 On a tick, if COUNT==COMPARE, the block SHALL set MATCH, and COUNT SHALL become 0 if AUTO_RELOAD=1, else COUNT+1.
REQ-020 On a tick, if COUNT is 0xFFFFFFFF with no reload, COUNT SHALL wrap to 0 and set OVF; MATCH and OVF can set in the same cycle.
REQ-021 An accepted COUNT write coinciding with a tick SHALL win; that tick's increment and match are discarded.
REQ-022 A W1C write coinciding with a set event on the same bit SHALL leave the bit set.
REQ-023 inr_irq SHALL be a registered copy of IRQ_EN & (MATCH | OVF), valid one cycle after the state change.

Reset
REQ-024 On reset_n low, asynchronously and regardless of FSM state:
- Registers: COUNT=0, COMPARE=0xFFFFFFFF, CTRL=0, STATUS=0, prescale counter=0.
- FSM returns to IDLE.
- Outputs: avs_readdata=0, avs_readdatavalid=0, avs_waitrequest=0, inr_irq=0.
REQ-025 A read in flight when reset asserts SHALL produce no response after release.

Structure
REQ-026 The shared package SHALL define register offset constants, the CTRL/STATUS bit positions and the FSM state enum.
REQ-027 A single sub-module, timer_prescaler (inputs: enable, clear, limit; output: tick), SHALL implement REQ-017/018.

Verification
REQ-028 PRESCALE=0, COMPARE=5, EN=1, IRQ_EN=1 -> COUNT 0..5, then MATCH=1, inr_irq=1 one cycle later, COUNT=6.
REQ-029 COUNT=0xFFFFFFFE, PRESCALE=3, EN=1 -> ticks every 4 cycles; OVF=1 and COUNT=0 on the second tick.
REQ-030 AUTO_RELOAD=1, COMPARE=2 -> COUNT sequence 0,1,2,0,1,2; STATUS W1C 0x1 clears MATCH and drops inr_irq.
REQ-031 Write COUNT=0x100 on the same edge as a tick -> COUNT=0x100; byteenable=0b0010 write of 0xAABBCCDD -> only bits[15:8]=0xCC change.
REQ-032 Back-to-back reads of COMPARE -> waitrequest pattern 1,0 per access, readdatavalid one cycle after acceptance, data 0xFFFFFFFF after reset.
REQ-033 Assert reset_n low in ACCEPT of a read -> no readdatavalid, all registers at reset values, inr_irq=0.
